// File: rtl/mem_access_arbiter_if.sv
// Requester and memory-side signal bundle for mem_access_arbiter.
// The arbiter takes the slave view; requesters and the byte memory sit on the master side.
interface mem_access_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [DATA_W-1:0] mem_data;
  logic              mem_store;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_q,
    output ack0, ack1, rdata, busy,
    output mem_data, mem_store, mem_addr
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_q,
    input  ack0, ack1, rdata, busy,
    input  mem_data, mem_store, mem_addr
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing a 4-byte level-sensitive memory between two requesters,
// sequencing writes as setup/strobe/hold so addr/data never move while store is high.
module mem_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input logic                 clk,
  input logic                 reset,
  mem_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RSETTLE,
    RCAP,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_id_q, gnt_id_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              win_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // On a tie the requester that did not win last time is served, which
  // makes grants strictly alternate when both requests are held.
  always_comb begin
    win_id = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_id = ~rr_last_q;
    end else if (bus.req1) begin
      win_id = 1'b1;
    end
    win_we    = win_id ? bus.we1    : bus.we0;
    win_addr  = win_id ? bus.addr1  : bus.addr0;
    win_wdata = win_id ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    rr_last_d  = rr_last_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_id_d   = win_id;
          rr_last_d  = win_id;
          mem_addr_d = win_addr;
          mem_data_d = win_wdata;
          state_d    = win_we ? SETUP : RSETTLE;
        end
      end
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = DONE;
      RSETTLE: state_d = RCAP;
      RCAP: begin
        rdata_d = bus.mem_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_id_q   <= 1'b0;
      rr_last_q  <= 1'b1;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      rr_last_q  <= rr_last_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rdata_q    <= rdata_d;
    end
  end

  // Strobe, ack and busy are pure state decodes, so a reset edge drops them together.
  assign bus.mem_store = (state_q == STROBE);
  assign bus.ack0      = (state_q == DONE) && !gnt_id_q;
  assign bus.ack1      = (state_q == DONE) &&  gnt_id_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a behavioural 4-byte memory.
module tb_mem_access_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef struct packed {
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem_arr [4] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [4] = '{default: '0};
  txn_t sb_q [$];
  txn_t mon_t;
  int tests_run = 0;
  int tests_failed = 0;
  int store_cnt = 0;

  // Byte store modelled as capturing mid-strobe; output is combinational from addr.
  always @(negedge clk) begin
    if (bus.mem_store === 1'b1) mem_arr[bus.mem_addr] <= bus.mem_data;
  end
  assign bus.mem_q = mem_arr[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_store === 1'b1) store_cnt++;
    if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
      tests_run++;
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) begin
        tests_failed++;
        $display("FAIL sb_dual_ack: got ack0=%b ack1=%b required one-hot", bus.ack0, bus.ack1);
      end else if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_ack: got ack1=%b with no transaction pending", bus.ack1);
      end else begin
        mon_t = sb_q.pop_front();
        if (bus.ack1 !== mon_t.id) begin
          tests_failed++;
          $display("FAIL sb_id: got requester %b required %b", bus.ack1, mon_t.id);
        end else if (!mon_t.we && bus.rdata !== mon_t.data) begin
          tests_failed++;
          $display("FAIL sb_rdata: addr %0d got %02h required %02h", mon_t.addr, bus.rdata, mon_t.data);
        end
      end
    end
  end

  task automatic push_txn(input logic id, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
    txn_t t;
    t.id = id;
    t.we = we;
    t.addr = addr;
    if (we) begin
      ref_mem[addr] = data;
      t.data = data;
    end else begin
      t.data = ref_mem[addr];
    end
    sb_q.push_back(t);
  endtask

  task automatic wait_any_ack(input int max_cyc, output int cyc, output int id);
    int i;
    cyc = -1;
    id = -1;
    i = 0;
    while (cyc < 0 && i < max_cyc) begin
      i++;
      @(posedge clk);
      @(negedge clk);
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        cyc = i;
        id = (bus.ack1 === 1'b1) ? 1 : 0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ack: got %b%b required 00", bus.ack0, bus.ack1);
    end
    tests_run++;
    if (bus.mem_store !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_store_busy: got %b%b required 00", bus.mem_store, bus.busy);
    end
    tests_run++;
    if (bus.rdata !== 8'h00 || bus.mem_data !== 8'h00 || bus.mem_addr !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got rdata=%02h mem_data=%02h mem_addr=%0d required 0",
               bus.rdata, bus.mem_data, bus.mem_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int c, ack_at, store_hi, store_at, cyc, id;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'hA5;
    push_txn(1'b0, 1'b1, 2'd2, 8'hA5);
    c = 0; ack_at = -1; store_hi = 0; store_at = -1;
    while (ack_at < 0 && c < 10) begin
      c++;
      @(posedge clk);
      @(negedge clk);
      if (c <= 3) begin
        tests_run++;
        if (bus.mem_addr !== 2'd2 || bus.mem_data !== 8'hA5) begin
          tests_failed++;
          $display("FAIL wr_stable c%0d: got addr=%0d data=%02h required 2/a5", c, bus.mem_addr, bus.mem_data);
        end
      end
      if (bus.mem_store === 1'b1) begin
        store_hi++;
        store_at = c;
      end
      if (bus.ack0 === 1'b1) ack_at = c;
    end
    bus.req0 = 1'b0;
    tests_run++;
    if (ack_at !== 4) begin
      tests_failed++;
      $display("FAIL wr_latency: got %0d required 4", ack_at);
    end
    tests_run++;
    if (store_hi !== 1 || store_at !== 2) begin
      tests_failed++;
      $display("FAIL wr_strobe: got %0d pulses at cycle %0d required 1 at 2", store_hi, store_at);
    end
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd2;
    push_txn(1'b0, 1'b0, 2'd2, 8'h00);
    wait_any_ack(10, cyc, id);
    bus.req0 = 1'b0;
    tests_run++;
    if (cyc !== 3 || id !== 0) begin
      tests_failed++;
      $display("FAIL rd_latency: got cycle %0d id %0d required 3 id 0", cyc, id);
    end
    tests_run++;
    if (bus.rdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL rd_value: got %02h required a5", bus.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int cyc, id;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd0; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 2'd1; bus.wdata1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_txn(1'b0, 1'b1, 2'd0, 8'h11);
      else            push_txn(1'b1, 1'b1, 2'd1, 8'h22);
    end
    for (int k = 0; k < 4; k++) begin
      wait_any_ack(12, cyc, id);
      tests_run++;
      if (id !== k % 2) begin
        tests_failed++;
        $display("FAIL rr_order grant%0d: got id %0d required %0d", k, id, k % 2);
      end
      if (k == 0) begin
        tests_run++;
        if (cyc !== 4) begin
          tests_failed++;
          $display("FAIL rr_first_latency: got %0d required 4", cyc);
        end
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_all();
    int cyc, id, s0;
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 8'(1 << i);
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'(i); bus.wdata0 = v;
      push_txn(1'b0, 1'b1, 2'(i), v);
      wait_any_ack(10, cyc, id);
      bus.req0 = 1'b0;
      tests_run++;
      if (cyc !== 4) begin
        tests_failed++;
        $display("FAIL fill_latency addr%0d: got %0d required 4", i, cyc);
      end
      @(negedge clk);
    end
    s0 = store_cnt;
    for (int i = 0; i < 4; i++) begin
      v = 8'(1 << i);
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'(i);
      push_txn(1'b1, 1'b0, 2'(i), 8'h00);
      wait_any_ack(10, cyc, id);
      bus.req1 = 1'b0;
      tests_run++;
      if (id !== 1 || bus.rdata !== v) begin
        tests_failed++;
        $display("FAIL readall addr%0d: got id %0d data %02h required id 1 data %02h", i, id, bus.rdata, v);
      end
      @(negedge clk);
    end
    tests_run++;
    if (store_cnt !== s0) begin
      tests_failed++;
      $display("FAIL read_no_store: got %0d strobes required 0", store_cnt - s0);
    end
  endtask

  task automatic test_mid_change();
    int cyc, id;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd0; bus.wdata0 = 8'h5A;
    push_txn(1'b0, 1'b1, 2'd0, 8'h5A);
    @(posedge clk);
    @(negedge clk);
    bus.addr0 = 2'd3; bus.wdata0 = 8'hFF;
    wait_any_ack(10, cyc, id);
    bus.req0 = 1'b0;
    tests_run++;
    if (id !== 0) begin
      tests_failed++;
      $display("FAIL mid_ack: got id %0d required 0", id);
    end
    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd0;
    push_txn(1'b1, 1'b0, 2'd0, 8'h00);
    wait_any_ack(10, cyc, id);
    bus.req1 = 1'b0;
    tests_run++;
    if (bus.rdata !== 8'h5A) begin
      tests_failed++;
      $display("FAIL mid_orig_addr: got %02h required 5a", bus.rdata);
    end
    @(negedge clk);
    bus.req1 = 1'b1; bus.addr1 = 2'd3;
    push_txn(1'b1, 1'b0, 2'd3, 8'h00);
    wait_any_ack(10, cyc, id);
    bus.req1 = 1'b0;
    tests_run++;
    if (bus.rdata !== 8'h08) begin
      tests_failed++;
      $display("FAIL mid_addr3_untouched: got %02h required 08", bus.rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_strobe();
    int cyc, id;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd1; bus.wdata0 = 8'h77;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.mem_store !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_strobe: got %b required 1", bus.mem_store);
    end
    ref_mem[1] = 8'h77;
    reset = 1'b1;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 2'd2; bus.wdata1 = 8'h33;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.mem_store !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_strobe_abort: got store=%b busy=%b required 0 0", bus.mem_store, bus.busy);
    end
    tests_run++;
    if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_ack: got %b%b required 00", bus.ack0, bus.ack1);
    end
    reset = 1'b0;
    push_txn(1'b0, 1'b1, 2'd1, 8'h77);
    push_txn(1'b1, 1'b1, 2'd2, 8'h33);
    wait_any_ack(10, cyc, id);
    bus.req0 = 1'b0;
    tests_run++;
    if (id !== 0 || cyc !== 4) begin
      tests_failed++;
      $display("FAIL rst_tie_first: got id %0d cycle %0d required id 0 cycle 4", id, cyc);
    end
    wait_any_ack(12, cyc, id);
    bus.req1 = 1'b0;
    tests_run++;
    if (id !== 1) begin
      tests_failed++;
      $display("FAIL rst_tie_second: got id %0d required 1", id);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, id;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd3; bus.wdata0 = 8'hC3;
    push_txn(1'b0, 1'b1, 2'd3, 8'hC3);
    push_txn(1'b0, 1'b1, 2'd3, 8'hC3);
    wait_any_ack(10, cyc, id);
    tests_run++;
    if (cyc !== 4 || id !== 0) begin
      tests_failed++;
      $display("FAIL b2b_first: got cycle %0d id %0d required 4 id 0", cyc, id);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_gap: got busy %b required 0", bus.busy);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_restart: got busy %b required 1", bus.busy);
    end
    wait_any_ack(10, cyc, id);
    bus.req0 = 1'b0;
    tests_run++;
    if (cyc !== 3 || id !== 0) begin
      tests_failed++;
      $display("FAIL b2b_second: got cycle %0d id %0d required 3 id 0", cyc, id);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_read_all();
    test_mid_change();
    test_reset_strobe();
    test_back_to_back();
    repeat (2) @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Sequences and shares the 4 x 8-bit byte memory system between two requesters (index 0 = switch panel, index 1 = auto-sequencer/scan logic). Each requester issues read or write transactions over a req/ack handshake. The block grants one requester at a time by round-robin and drives the memory's data/store/addr inputs with a setup/strobe/hold write sequence, so that the level-sensitive byte stores never see addr or data change while store is high. Reads select the byte, wait one settle cycle and register the memory output.

Parameters:
DATA_W, 8, width of a memory byte and of the data buses
ADDR_W, 2, memory address width (4 locations)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 transaction request; held high until ack0
we0  input  1  requester 0: 1 = write, 0 = read; sampled at grant
addr0  input  ADDR_W  requester 0 address; sampled at grant
wdata0  input  DATA_W  requester 0 write data; sampled at grant
ack0  output  1  one-cycle pulse: requester 0 transaction complete
req1, we1, addr1, wdata1, ack1  same as requester 0, for requester 1
rdata  output  DATA_W  read result; valid in the ack cycle of a read, held until next read completes
mem_data  output  DATA_W  to memory system data input
mem_store  output  1  to memory system store input
mem_addr  output  ADDR_W  to memory system addr input
mem_q  input  DATA_W  from memory system memory output (combinational from mem_addr)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: ack0 = ack1 = 0, rdata = 0, mem_data = 0, mem_store = 0, mem_addr = 0, busy = 0, state = IDLE, rr_last = 1 (requester 0 wins the first tie).
- States: IDLE, SETUP, STROBE, HOLD, RSETTLE, RCAP, DONE.
- IDLE: if no req, stay. If exactly one req is high, grant it. If both are high, grant the requester not equal to rr_last. On grant, latch the winner's id, we, addr and wdata, update rr_last to the winner, and drive mem_addr and mem_data from the latched values on the same edge. Next state is SETUP if we = 1, else RSETTLE.
- Write path:
  - SETUP: mem_store = 0.
  - STROBE: mem_store = 1.
  - HOLD: mem_store = 0.
  - Then DONE. mem_addr and mem_data are stable from SETUP through HOLD inclusive.
- Read path:
  - RSETTLE: mem_addr stable, mem_store = 0.
  - RCAP: rdata <= mem_q at the end of the cycle.
  - Then DONE.
- DONE: ack of the granted requester = 1 for exactly this one cycle; the other ack stays 0. Next state is IDLE.
- Latency, counted from the first IDLE cycle in which req is sampled high:
  - Write: ack in cycle +4.
  - Read: ack in cycle +3, with rdata valid in that cycle.
- A req still high in the cycle after ack is a new transaction and is arbitrated normally.
- Requests arriving while busy wait. There is no queueing beyond the level-held req.
- mem_addr and mem_data keep their last values in IDLE and DONE; they are never returned to 0 except by reset.
- mem_store is high only in STROBE, for exactly one cycle per write, and never during a read.
- Changes to req, addr or wdata after grant have no effect on the transaction in flight.
- Reset mid-operation: at the next rising edge with reset high, all outputs return to their reset values and the state goes to IDLE. The in-flight transaction is abandoned with no ack. If reset lands in STROBE, mem_store is low from that edge.
- Starvation bound: with both reqs continuously high, grants strictly alternate 0, 1, 0, 1, ...

Test Plan:
- Write, then read back: reset, then req0 = 1, we0 = 1, addr0 = 2, wdata0 = 0xA5 → mem_store high for exactly one cycle, with mem_addr = 2 and mem_data = 0xA5 stable from SETUP through HOLD; ack0 4 cycles after req. Then read addr 2 → ack0 3 cycles after req, rdata = 0xA5.
- Simultaneous requests: req0 and req1 rise together, both writes (addr 0 = 0x11, addr 1 = 0x22), both held → grants in order 0 then 1. Keep both reqs high continuously for 4 transactions → grants alternate 0, 1, 0, 1.
- Read all locations: fill addresses 0–3 with 0x01, 0x02, 0x04, 0x08 → reads via requester 1 return the same values; mem_store never pulses during the reads.
- Mid-transaction input change: change addr0 and wdata0 to 3 / 0xFF one cycle after grant → memory at the original address gets the original data; location 3 is unchanged.
- Reset during STROBE: assert reset while mem_store = 1 → next edge gives mem_store = 0, busy = 0, no ack. A subsequent req1 tie with req0 grants requester 0 first.
- Back-to-back: hold req0 high through ack → a second transaction starts in the cycle after DONE; busy drops for exactly one cycle (DONE → IDLE).
